matrix_addsub_seq: RTL and testbench
====================================

// Module: matrix_addsub_seq
// PURPOSE
//  Sequential, parametrised element-wise matrix add/subtract engine for the
//  FastICA datapath (e.g. W - W_old convergence deltas, mean removal).
//  Processes LANES elements per clock in row-major order, with start/done
//  handshake, runtime add/sub mode, optional saturation and sticky overflow.
//  Replaces purely combinational subtraction where timing over large matrices fails.
// PARAMETERS
//  SIZE_A    8   rows
//  SIZE_B    8   columns
//  WIDTH     32  signed element width (two's complement), inputs and outputs
//  LANES     4   elements processed per cycle, 1..SIZE_A*SIZE_B
//  SATURATE  1   1: clamp results to WIDTH range; 0: wrap modulo 2^WIDTH
// PORTS
//  clk         in   1                     clock, rising edge
//  rst_n       in   1                     asynchronous active-low reset
//  start       in   1                     request operation; sampled only in IDLE
//  mode        in   1                     0: out = A - B; 1: out = A + B; latched at start
//  mat_a       in   [SIZE_A][SIZE_B]xWIDTH  operand A, signed
//  mat_b       in   [SIZE_A][SIZE_B]xWIDTH  operand B, signed
//  out_matrix  out  [SIZE_A][SIZE_B]xWIDTH  registered result, signed
//  busy        out  1                     high in RUN
//  done        out  1                     one-cycle pulse, result complete
//  overflow    out  1                     sticky: any element overflowed this operation
// BEHAVIOUR
//  - N = SIZE_A*SIZE_B; BEATS = ceil(N/LANES); flat index k = i*SIZE_B + j.
//  - Reset (rst_n=0, async): state=IDLE, out_matrix all 0, busy=0, done=0,
//    overflow=0, beat index=0. Reset mid-operation aborts; no partial results kept.
//  - FSM IDLE -> RUN -> DONE -> IDLE; busy/done decoded from state (Moore).
//    IDLE: start=1 at edge E0 -> RUN, latch mode, index=0, clear overflow.
//    RUN: each edge writes elements index..index+LANES-1; indices >= N are
//      skipped (no write, no overflow contribution); index += LANES.
//      Edge EBEATS writes last beat -> DONE.
//    DONE: done=1, busy=0 for exactly one cycle; next edge -> IDLE.
//  - Latency: busy high cycles 1..BEATS after E0; done high in cycle BEATS+1;
//    out_matrix fully valid from that cycle and held until next start.
//  - start while RUN or DONE: ignored (not queued). mode changes after start ignored.
//  - mat_a/mat_b are not latched: caller holds them stable from E0 until done.
//  - Elements not yet written in RUN keep their previous value.
//  - Arithmetic: sum computed in WIDTH+1 bits. Overflow if result outside
//    [-2^(WIDTH-1), 2^(WIDTH-1)-1]. SATURATE=1: clamp to nearest bound;
//    SATURATE=0: keep low WIDTH bits. overflow flag is set in both cases,
//    stays high until the next accepted start or reset.
//  - Lane writes for one beat occur on the same edge; no element written twice.
// TESTING
//  1. Reset asserted mid-idle and mid-RUN -> out_matrix all 0, busy=0, done=0, overflow=0
//     immediately (async), FSM in IDLE after release.
//  2. 8x8, LANES=4, mode=0, a[i][j]=8i+j, b=1, start at E0 -> busy cycles 1..16,
//     done=1 only in cycle 17, out[i][j]=8i+j-1, overflow=0.
//  3. mode=1, a[0][0]=2^31-1, b[0][0]=1, rest 0: SATURATE=1 -> out[0][0]=2^31-1,
//     overflow=1; SATURATE=0 -> out[0][0]=-2^31, overflow=1.
//  4. mode=0, a[2][3]=-2^31, b[2][3]=1, SATURATE=1 -> out[2][3]=-2^31, overflow=1;
//     next start with benign data -> overflow cleared to 0.
//  5. SIZE_A=SIZE_B=3, LANES=4 -> BEATS=3, done in cycle 4, all 9 results correct,
//     no X/out-of-range writes; also LANES=1 (64 beats) and LANES=64 (1 beat) at 8x8.
//  6. start pulsed during RUN and during DONE -> ignored, single done pulse;
//     rst_n low at beat 5 then new start -> complete correct result, done at BEATS+1.

Source files
------------

// File: rtl/matrix_addsub_seq.sv
// Element-wise signed matrix add/subtract, LANES elements per cycle in row-major order.
// Latency: done pulses BEATS+1 cycles after start; no backpressure, start is ignored unless idle.
module matrix_addsub_seq #(
  parameter int SIZE_A   = 8,
  parameter int SIZE_B   = 8,
  parameter int WIDTH    = 32,
  parameter int LANES    = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic                                     mode,
  input  logic [SIZE_A-1:0][SIZE_B-1:0][WIDTH-1:0] mat_a,
  input  logic [SIZE_A-1:0][SIZE_B-1:0][WIDTH-1:0] mat_b,
  output logic [SIZE_A-1:0][SIZE_B-1:0][WIDTH-1:0] out_matrix,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     overflow
);

  localparam int N  = SIZE_A * SIZE_B;
  localparam int IW = $clog2(N + LANES + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [N-1:0][WIDTH-1:0] flat_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          mode_q, mode_d;
  logic          ovf_q, ovf_d;
  flat_t         out_q, out_d;
  flat_t         a_flat, b_flat;
  logic [WIDTH:0] lane_res;

  // Row-major packing makes the 2-D operands bit-identical to a flat k = i*SIZE_B + j view.
  assign a_flat = mat_a;
  assign b_flat = mat_b;

  // Returns {overflow, result}; the sum is formed one bit wider so the sign never wraps.
  function automatic logic [WIDTH:0] addsub(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic             add);
    logic signed [WIDTH:0] s;
    logic                  ov;
    logic [WIDTH-1:0]      res;
    if (add) s = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
    else     s = $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
    ov = s[WIDTH] ^ s[WIDTH-1];
    if (ov && SATURATE) res = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else                res = s[WIDTH-1:0];
    return {ov, res};
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mode_d   = mode_q;
    ovf_d    = ovf_q;
    out_d    = out_q;
    lane_res = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mode_d  = mode;
          idx_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        // Only elements inside the current beat window are touched; the last beat may be partial.
        for (int k = 0; k < N; k++) begin
          if (IW'(k) >= idx_q && IW'(k) < idx_q + IW'(LANES)) begin
            lane_res = addsub(a_flat[k], b_flat[k], mode_q);
            out_d[k] = lane_res[WIDTH-1:0];
            if (lane_res[WIDTH]) ovf_d = 1'b1;
          end
        end
        idx_d = idx_q + IW'(LANES);
        if (idx_q + IW'(LANES) >= IW'(N)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
      out_q   <= out_d;
    end
  end

  assign out_matrix = out_q;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_matrix_addsub_seq.sv
// Bench for matrix_addsub_seq: five configurations run side by side against a plain-arithmetic model.
module tb_matrix_addsub_seq;
  localparam int W = 32;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  // Instance order: 8x8 L4 sat, 8x8 L4 wrap, 3x3 L4 sat, 8x8 L1 sat, 8x8 L64 wrap
  localparam int BEATS [5] = '{16, 16, 3, 64, 1};
  localparam int NELEM [5] = '{64, 64, 9, 64, 64};
  localparam bit SATC  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] start_v;
  logic       mode;
  logic [7:0][7:0][W-1:0] mat_a, mat_b;
  logic [2:0][2:0][W-1:0] mat_as, mat_bs;
  logic [7:0][7:0][W-1:0] out_big [4];
  logic [2:0][2:0][W-1:0] out_small;
  logic [4:0] busy_v, done_v, ovf_v;

  int am [64];
  int bm [64];
  int n_checks = 0;
  int n_err    = 0;

  matrix_addsub_seq #(.SIZE_A(8), .SIZE_B(8), .WIDTH(W), .LANES(4), .SATURATE(1'b1)) u_l4s (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode), .mat_a(mat_a), .mat_b(mat_b),
    .out_matrix(out_big[0]), .busy(busy_v[0]), .done(done_v[0]), .overflow(ovf_v[0]));
  matrix_addsub_seq #(.SIZE_A(8), .SIZE_B(8), .WIDTH(W), .LANES(4), .SATURATE(1'b0)) u_l4w (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode), .mat_a(mat_a), .mat_b(mat_b),
    .out_matrix(out_big[1]), .busy(busy_v[1]), .done(done_v[1]), .overflow(ovf_v[1]));
  matrix_addsub_seq #(.SIZE_A(3), .SIZE_B(3), .WIDTH(W), .LANES(4), .SATURATE(1'b1)) u_3x3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mode(mode), .mat_a(mat_as), .mat_b(mat_bs),
    .out_matrix(out_small), .busy(busy_v[2]), .done(done_v[2]), .overflow(ovf_v[2]));
  matrix_addsub_seq #(.SIZE_A(8), .SIZE_B(8), .WIDTH(W), .LANES(1), .SATURATE(1'b1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .mode(mode), .mat_a(mat_a), .mat_b(mat_b),
    .out_matrix(out_big[2]), .busy(busy_v[3]), .done(done_v[3]), .overflow(ovf_v[3]));
  matrix_addsub_seq #(.SIZE_A(8), .SIZE_B(8), .WIDTH(W), .LANES(64), .SATURATE(1'b0)) u_l64 (
    .clk(clk), .rst_n(rst_n), .start(start_v[4]), .mode(mode), .mat_a(mat_a), .mat_b(mat_b),
    .out_matrix(out_big[3]), .busy(busy_v[4]), .done(done_v[4]), .overflow(ovf_v[4]));

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] got(input int inst, input int k);
    int bi;
    if (inst == 2) return 64'($signed(out_small[k/3][k%3]));
    bi = (inst < 2) ? inst : inst - 1;
    return 64'($signed(out_big[bi][k/8][k%8]));
  endfunction

  // Reference: exact integer result, then clamp or wrap to 32 bits
  function automatic longint ref_elem(input int a, input int b, input bit m, input bit sat, output bit ov);
    longint r;
    r  = m ? longint'(a) + longint'(b) : longint'(a) - longint'(b);
    ov = (r > MAXV) || (r < MINV);
    if (!ov) return r;
    if (sat) return (r > 0) ? MAXV : MINV;
    return longint'(int'(r));
  endfunction

  task automatic load();
    for (int k = 0; k < 64; k++) begin
      mat_a[k/8][k%8] = am[k];
      mat_b[k/8][k%8] = bm[k];
    end
    for (int k = 0; k < 9; k++) begin
      mat_as[k/3][k%3] = am[k];
      mat_bs[k/3][k%3] = bm[k];
    end
  endtask

  function automatic int rand_val();
    case ($urandom_range(0, 7))
      0:       return int'(MAXV);
      1:       return int'(MINV);
      2:       return int'($urandom_range(0, 3)) - 2;
      default: return int'($urandom);
    endcase
  endfunction

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 5; i++) begin
      check({tag, "_busy"}, 64'(busy_v[i]), 0);
      check({tag, "_done"}, 64'(done_v[i]), 0);
      check({tag, "_ovf"},  64'(ovf_v[i]), 0);
      if (i == 2) check({tag, "_out"}, 64'(|out_small), 0);
      else        check({tag, "_out"}, 64'(|out_big[(i < 2) ? i : i - 1]), 0);
    end
  endtask

  // Starts all instances, tracks busy/done per cycle, optionally pokes start/mode while they are active.
  task automatic run_op(input bit m, input bit glitch);
    int  busy_bad [5];
    int  done_cnt [5];
    int  done_at  [5];
    bit  ov;
    bit  ovf_exp;
    longint e;
    for (int i = 0; i < 5; i++) begin busy_bad[i] = 0; done_cnt[i] = 0; done_at[i] = -1; end
    load();
    @(negedge clk);
    mode = m; start_v = '1;
    @(negedge clk);
    start_v = '0;
    for (int c = 1; c <= 70; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (busy_v[i] !== (c <= BEATS[i])) busy_bad[i]++;
        if (done_v[i] === 1'b1) begin done_cnt[i]++; done_at[i] = c; end
      end
      if (glitch) begin
        start_v = '0;
        for (int i = 0; i < 5; i++)
          if (c <= BEATS[i] + 1 && $urandom_range(0, 1) == 1) start_v[i] = 1'b1;
        mode = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    start_v = '0;
    mode = m;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("busy_window%0d", i), busy_bad[i], 0);
      check($sformatf("done_pulses%0d", i), done_cnt[i], 1);
      check($sformatf("done_cycle%0d", i), done_at[i], BEATS[i] + 1);
      ovf_exp = 1'b0;
      for (int k = 0; k < NELEM[i]; k++) begin
        e = ref_elem(am[k], bm[k], m, SATC[i], ov);
        ovf_exp |= ov;
        check($sformatf("out%0d[%0d]", i, k), got(i, k), e);
      end
      check($sformatf("overflow%0d", i), 64'(ovf_v[i]), 64'(ovf_exp));
    end
  endtask

  initial begin
    rst_n = 1'b0; start_v = '0; mode = 1'b0;
    for (int k = 0; k < 64; k++) begin am[k] = 0; bm[k] = 0; end
    load();
    #12;
    check_reset_state("reset_init");
    @(negedge clk);
    rst_n = 1'b1;

    // Ramp minus one
    for (int k = 0; k < 64; k++) begin am[k] = k; bm[k] = 1; end
    run_op(1'b0, 1'b0);

    // Positive overflow at [0][0]
    for (int k = 0; k < 64; k++) begin am[k] = 0; bm[k] = 0; end
    am[0] = int'(MAXV); bm[0] = 1;
    run_op(1'b1, 1'b0);

    // Negative overflow at [2][3], then benign data clears the flag
    for (int k = 0; k < 64; k++) begin am[k] = 0; bm[k] = 0; end
    am[19] = int'(MINV); bm[19] = 1;
    run_op(1'b0, 1'b0);
    for (int k = 0; k < 64; k++) begin am[k] = k; bm[k] = 3 * k; end
    run_op(1'b1, 1'b0);

    // Random data with stray start/mode activity while busy or done
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 64; k++) begin am[k] = rand_val(); bm[k] = rand_val(); end
      run_op(1'($urandom_range(0, 1)), 1'b1);
    end

    // Asynchronous reset while idle with results held
    #2 rst_n = 1'b0;
    #1 check_reset_state("reset_idle");
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a run, then a clean run
    for (int k = 0; k < 64; k++) begin am[k] = rand_val(); bm[k] = rand_val(); end
    load();
    @(negedge clk);
    mode = 1'b1; start_v = '1;
    @(negedge clk);
    start_v = '0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_state("reset_run");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 64; k++) begin am[k] = rand_val(); bm[k] = rand_val(); end
    run_op(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
